// File: rtl/uart_apb_console.sv
// uart_apb_console: autonomous APB master sitting in front of a UART16550
// APB slave. After reset it programs the divisor latch and line control,
// then polls LSR and moves bytes between two valid/ready byte streams and
// the UART's THR/RBR. SoC logic never touches UART registers directly.
module uart_apb_console #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [15:0] DIVISOR   = 16'h0001
) (
  input  logic        clock,
  input  logic        reset,
  // APB master port towards the UART
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [31:0] out_paddr,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  output logic [2:0]  out_pprot,
  input  logic        out_pready,
  input  logic        out_pslverr,
  input  logic [31:0] out_prdata,
  // TX byte stream (SoC -> UART)
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  // RX byte stream (UART -> SoC)
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  // status
  output logic        init_done,
  output logic        err
);

  // UART register offsets. Offset 0 is RBR on read, THR on write and DLL
  // while DLAB is set.
  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_DLM  = 3'd1;
  localparam logic [2:0] REG_LCR  = 3'd3;
  localparam logic [2:0] REG_LSR  = 3'd5;

  // LSR bits used by the poll loop
  localparam int LSR_DR   = 0;  // receive data ready
  localparam int LSR_THRE = 5;  // transmit holding register empty

  // LCR values: DLAB set for divisor access, then 8N1 with DLAB cleared
  localparam logic [7:0] LCR_DLAB_8N1 = 8'h83;
  localparam logic [7:0] LCR_8N1      = 8'h03;

  typedef enum logic [2:0] {
    INIT0,   // LCR <- 8'h83
    INIT1,   // DLL <- DIVISOR[7:0]
    INIT2,   // DLM <- DIVISOR[15:8]
    INIT3,   // LCR <- 8'h03
    DECIDE,  // turnaround; decide whether to poll
    POLL,    // read LSR
    RD_RBR,  // read received byte
    WR_THR   // write held TX byte
  } state_t;

  state_t      state;
  logic        tx_full;
  logic [7:0]  tx_buf;
  logic [7:0]  lsr_q;

  // request for the transfer the current state would issue next
  logic [2:0]  req_off;
  logic        req_write;
  logic [7:0]  req_byte;

  logic        access_done;
  logic        issue_ok;
  logic        rbr_done;
  logic        thr_done;

  // The slave replicates its byte in every lane, so only lane 0 is consumed;
  // lsr_q is kept as a debug-visible copy of the last LSR value.
  logic        unused_bits;
  assign unused_bits = ^{out_prdata[31:8], lsr_q};

  // Byte-lane strobe for register offset n; reads drive it too because the
  // slave decodes its register from the strobe.
  function automatic logic [3:0] strb_for(input logic [2:0] off);
    return 4'b0001 << off[1:0];
  endfunction

  // Write data placed in the byte lane of the register, other lanes zero.
  function automatic logic [31:0] lane_for(input logic [2:0] off, input logic [7:0] b);
    return {24'h00_0000, b} << {off[1:0], 3'b000};
  endfunction

  assign out_pprot   = 3'b000;
  assign tx_ready    = ~tx_full;
  assign access_done = out_psel & out_penable & out_pready;
  assign rbr_done    = access_done & (state == RD_RBR);
  assign thr_done    = access_done & (state == WR_THR);
  // In DECIDE the poll is skipped only while a received byte is parked and
  // there is nothing to send.
  assign issue_ok    = (state != DECIDE) | ~rx_valid | tx_full;

  // Decode the register access belonging to the current state.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave one
    // unassigned and infer a latch.
    req_off   = REG_LSR;
    req_write = 1'b0;
    req_byte  = 8'h00;
    case (state)
      INIT0: begin
        req_off   = REG_LCR;
        req_write = 1'b1;
        req_byte  = LCR_DLAB_8N1;
      end
      INIT1: begin
        req_off   = REG_DATA;
        req_write = 1'b1;
        req_byte  = DIVISOR[7:0];
      end
      INIT2: begin
        req_off   = REG_DLM;
        req_write = 1'b1;
        req_byte  = DIVISOR[15:8];
      end
      INIT3: begin
        req_off   = REG_LCR;
        req_write = 1'b1;
        req_byte  = LCR_8N1;
      end
      RD_RBR: begin
        req_off   = REG_DATA;
      end
      WR_THR: begin
        req_off   = REG_DATA;
        req_write = 1'b1;
        req_byte  = tx_buf;
      end
      default: begin
        // DECIDE and POLL both stand for the LSR read
      end
    endcase
  end

  // Sequencer and APB phase generator: an idle (psel=0) cycle in a state
  // launches its SETUP, SETUP moves to ACCESS, ACCESS waits for pready.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset) begin
      state       <= INIT0;
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      out_pwrite  <= 1'b0;
      out_paddr   <= BASE_ADDR;
      out_pwdata  <= 32'h0000_0000;
      out_pstrb   <= 4'b0000;
      lsr_q       <= 8'h00;
      init_done   <= 1'b0;
    end else if (!out_psel) begin
      if (issue_ok) begin
        out_psel    <= 1'b1;
        out_penable <= 1'b0;
        out_pwrite  <= req_write;
        out_paddr   <= BASE_ADDR + {29'd0, req_off};
        out_pstrb   <= strb_for(req_off);
        out_pwdata  <= req_write ? lane_for(req_off, req_byte) : 32'h0000_0000;
        if (state == DECIDE) begin
          state <= POLL;
        end
      end
    end else if (!out_penable) begin
      out_penable <= 1'b1;
    end else if (out_pready) begin
      // transfer completes; the next cycle is the psel=0 turnaround
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      case (state)
        INIT0: state <= INIT1;
        INIT1: state <= INIT2;
        INIT2: state <= INIT3;
        INIT3: begin
          state     <= DECIDE;
          init_done <= 1'b1;
        end
        POLL: begin
          lsr_q <= out_prdata[7:0];
          // RX first so the receiver is drained before it can overrun
          if (out_prdata[LSR_DR] && !rx_valid) begin
            state <= RD_RBR;
          end else if (out_prdata[LSR_THRE] && tx_full) begin
            state <= WR_THR;
          end else begin
            state <= DECIDE;
          end
        end
        default: state <= DECIDE;
      endcase
    end
  end

  // One-byte TX holding register: filled by handshake, emptied by THR write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_full <= 1'b0;
      tx_buf  <= 8'h00;
    end else if (tx_valid && !tx_full) begin
      tx_full <= 1'b1;
      tx_buf  <= tx_data;
    end else if (thr_done) begin
      tx_full <= 1'b0;
    end
  end

  // One-byte RX slot: filled by an RBR read, emptied by handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else if (rbr_done) begin
      rx_valid <= 1'b1;
      rx_data  <= out_prdata[7:0];
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // Sticky slave-error flag; only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (out_psel && out_penable && out_pslverr) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_apb_console.sv
// tb_uart_apb_console: directed bench for uart_apb_console with a simple
// zero-wait APB slave whose LSR and RBR contents are set by the stimulus.
module tb_uart_apb_console;

  localparam logic [31:0] BASE     = 32'h1000_0000;
  localparam logic [31:0] LSR_ADDR = 32'h1000_0005;

  logic        clock;
  logic        reset;
  logic        out_psel, out_penable, out_pwrite;
  logic [31:0] out_paddr, out_pwdata;
  logic [3:0]  out_pstrb;
  logic [2:0]  out_pprot;
  logic        out_pready, out_pslverr;
  logic [31:0] out_prdata;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        init_done, err;

  logic [7:0]  lsr_val;
  logic [7:0]  rbr_val;

  int n_tests = 0;
  int n_fail  = 0;

  uart_apb_console #(
    .BASE_ADDR (BASE),
    .DIVISOR   (16'h0102)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .out_psel    (out_psel),
    .out_penable (out_penable),
    .out_pwrite  (out_pwrite),
    .out_paddr   (out_paddr),
    .out_pwdata  (out_pwdata),
    .out_pstrb   (out_pstrb),
    .out_pprot   (out_pprot),
    .out_pready  (out_pready),
    .out_pslverr (out_pslverr),
    .out_prdata  (out_prdata),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .init_done   (init_done),
    .err         (err)
  );

  // slave model: LSR at offset 5, RBR everywhere else, byte replicated
  assign out_prdata = (out_paddr == LSR_ADDR) ? {4{lsr_val}} : {4{rbr_val}};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // completed-transfer log
  typedef struct {
    int          cyc;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        held;
  } xfer_t;

  xfer_t       xlog[$];
  int          cyc = -1;
  int          thr_setup_cyc = -1;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_strb;
  logic        s_write;

  // cycle counter and bus monitor (samples pre-edge values)
  always @(posedge clock) begin
    if (!reset) begin
      cyc <= -1;
    end else begin
      cyc <= cyc + 1;
      if (out_psel && !out_penable) begin
        s_addr  <= out_paddr;
        s_wdata <= out_pwdata;
        s_strb  <= out_pstrb;
        s_write <= out_pwrite;
        if (out_pwrite && out_paddr == BASE) thr_setup_cyc <= cyc;
      end
      if (out_psel && out_penable && out_pready) begin
        xlog.push_back('{cyc, out_pwrite, out_paddr, out_pwdata, out_pstrb,
                         (out_paddr == s_addr) && (out_pwdata == s_wdata) &&
                         (out_pstrb == s_strb) && (out_pwrite == s_write)});
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int count_xfers(input logic w, input logic [31:0] a);
    int n = 0;
    foreach (xlog[i]) if (xlog[i].write == w && xlog[i].addr == a) n++;
    return n;
  endfunction

  function automatic int first_xfer(input logic w, input logic [31:0] a);
    foreach (xlog[i]) if (xlog[i].write == w && xlog[i].addr == a) return i;
    return -1;
  endfunction

  // hand a byte to the TX port; acc is the cycle in which the handshake occurs
  task automatic send_byte(input logic [7:0] b, output int acc);
    int k = 0;
    while (!tx_ready && k < 50) begin
      @(negedge clock);
      k++;
    end
    check("send_ready", tx_ready, 1'b1);
    acc      = cyc;
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  // wait (bounded) until a completed transfer of the given kind is logged
  task automatic wait_xfer(input string tag, input logic w, input logic [31:0] a);
    int k = 0;
    while (count_xfers(w, a) == 0 && k < 40) begin
      @(negedge clock);
      k++;
    end
    check(tag, count_xfers(w, a) > 0, 1'b1);
  endtask

  // wait (bounded) until the bus is in an ACCESS cycle of the given kind
  task automatic wait_access(input string tag, input logic w, input logic [31:0] a);
    logic found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_psel && out_penable && out_pwrite == w && out_paddr == a) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check(tag, found, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    int i_rbr;
    int i_thr;
    int n;

    reset       = 1'b0;
    out_pready  = 1'b1;
    out_pslverr = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    rx_ready    = 1'b0;
    lsr_val     = 8'h00;
    rbr_val     = 8'h00;

    // ---------------- reset values ----------------
    repeat (3) @(negedge clock);
    check("rst_psel",      out_psel,    1'b0);
    check("rst_penable",   out_penable, 1'b0);
    check("rst_pwrite",    out_pwrite,  1'b0);
    check("rst_pwdata",    out_pwdata,  32'h0);
    check("rst_pstrb",     out_pstrb,   4'b0000);
    check("rst_paddr",     out_paddr,   BASE);
    check("rst_tx_ready",  tx_ready,    1'b1);
    check("rst_rx_valid",  rx_valid,    1'b0);
    check("rst_rx_data",   rx_data,     8'h00);
    check("rst_init_done", init_done,   1'b0);
    check("rst_err",       err,         1'b0);
    check("pprot",         out_pprot,   3'b000);

    // ---------------- init sequence ----------------
    reset = 1'b1;
    @(negedge clock);
    check("init_c0_cyc",     cyc,         0);
    check("init_c0_psel",    out_psel,    1'b1);
    check("init_c0_penable", out_penable, 1'b0);
    repeat (10) @(negedge clock);
    check("init_c10_done",   init_done,   1'b0);
    @(negedge clock);
    check("init_c11_done",   init_done,   1'b1);
    check("init_c11_psel",   out_psel,    1'b0);
    check("init_nxfers",     xlog.size(), 4);
    if (xlog.size() >= 4) begin
      check("init0_addr",  xlog[0].addr,  BASE + 3);
      check("init0_strb",  xlog[0].strb,  4'b1000);
      check("init0_wdata", xlog[0].wdata, 32'h8300_0000);
      check("init1_addr",  xlog[1].addr,  BASE);
      check("init1_strb",  xlog[1].strb,  4'b0001);
      check("init1_wdata", xlog[1].wdata, 32'h0000_0002);
      check("init2_addr",  xlog[2].addr,  BASE + 1);
      check("init2_strb",  xlog[2].strb,  4'b0010);
      check("init2_wdata", xlog[2].wdata, 32'h0000_0100);
      check("init3_addr",  xlog[3].addr,  BASE + 3);
      check("init3_strb",  xlog[3].strb,  4'b1000);
      check("init3_wdata", xlog[3].wdata, 32'h0300_0000);
      check("init3_write", xlog[3].write, 1'b1);
      check("init3_cyc",   xlog[3].cyc,   10);
    end

    // ---------------- TX with THRE set, one wait state burst ----------------
    lsr_val = 8'h60;
    xlog.delete();
    repeat (3) @(negedge clock);
    send_byte(8'h41, acc);
    check("tx_ready_low", tx_ready, 1'b0);
    wait_access("tx_thr_access", 1'b1, BASE);
    check("tx_latency", (thr_setup_cyc - acc) <= 6, 1'b1);
    out_pready = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("tx_wait_held", {out_psel, out_penable, out_pwdata}, {2'b11, 32'h0000_0041});
      check("tx_wait_ready", tx_ready, 1'b0);
    end
    out_pready = 1'b1;
    @(negedge clock);
    check("tx_ready_back", tx_ready, 1'b1);
    check("tx_turn_psel",  out_psel, 1'b0);
    n = xlog.size();
    check("tx_nlog", n >= 2, 1'b1);
    if (n >= 2) begin
      check("tx_thr_write", xlog[n-1].write, 1'b1);
      check("tx_thr_addr",  xlog[n-1].addr,  BASE);
      check("tx_thr_strb",  xlog[n-1].strb,  4'b0001);
      check("tx_thr_wdata", xlog[n-1].wdata, 32'h0000_0041);
      check("tx_thr_held",  xlog[n-1].held,  1'b1);
      check("tx_poll_read", xlog[n-2].write, 1'b0);
      check("tx_poll_addr", xlog[n-2].addr,  LSR_ADDR);
      check("tx_poll_strb", xlog[n-2].strb,  4'b0010);
    end

    // ---------------- TX blocked by LSR=0 ----------------
    lsr_val = 8'h00;
    xlog.delete();
    send_byte(8'h33, acc);
    repeat (40) @(negedge clock);
    check("blk_no_write",  count_xfers(1'b1, BASE), 0);
    check("blk_polls",     count_xfers(1'b0, LSR_ADDR) >= 5, 1'b1);
    check("blk_tx_ready",  tx_ready, 1'b0);
    lsr_val = 8'h60;
    wait_xfer("blk_drain", 1'b1, BASE);
    if (xlog.size() > 0) check("blk_drain_data", xlog[xlog.size()-1].wdata, 32'h0000_0033);
    repeat (3) @(negedge clock);

    // ---------------- RX priority over pending TX ----------------
    lsr_val = 8'h00;
    send_byte(8'h77, acc);
    repeat (5) @(negedge clock);
    xlog.delete();
    rbr_val = 8'h5A;
    lsr_val = 8'h61;
    repeat (40) @(negedge clock);
    i_rbr = first_xfer(1'b0, BASE);
    i_thr = first_xfer(1'b1, BASE);
    check("rx_rbr_seen",   i_rbr >= 0, 1'b1);
    check("rx_before_tx",  i_thr > i_rbr, 1'b1);
    check("rx_one_rbr",    count_xfers(1'b0, BASE), 1);
    if (i_thr >= 0) check("rx_thr_data", xlog[i_thr].wdata, 32'h0000_0077);
    if (i_rbr >= 0) check("rx_rbr_strb", xlog[i_rbr].strb, 4'b0001);
    check("rx_valid",      rx_valid, 1'b1);
    check("rx_data",       rx_data,  8'h5A);
    check("rx_tx_ready",   tx_ready, 1'b1);
    // slot still full: a new TX byte goes out but RBR stays untouched
    xlog.delete();
    send_byte(8'h55, acc);
    repeat (20) @(negedge clock);
    check("rx_full_no_rbr", count_xfers(1'b0, BASE), 0);
    check("rx_full_thr",    count_xfers(1'b1, BASE), 1);
    check("rx_still_valid", rx_valid, 1'b1);
    lsr_val  = 8'h60;
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    check("rx_consumed", rx_valid, 1'b0);

    // ---------------- slave error on one LSR read ----------------
    check("slv_err_before", err, 1'b0);
    wait_access("slv_lsr_access", 1'b0, LSR_ADDR);
    out_pslverr = 1'b1;
    @(negedge clock);
    out_pslverr = 1'b0;
    check("slv_err_set", err, 1'b1);
    xlog.delete();
    send_byte(8'h12, acc);
    wait_xfer("slv_continue", 1'b1, BASE);
    if (xlog.size() > 0) check("slv_thr_data", xlog[xlog.size()-1].wdata, 32'h0000_0012);
    repeat (20) @(negedge clock);
    check("slv_err_sticky", err, 1'b1);

    // ---------------- reset during a THR access ----------------
    lsr_val = 8'h60;
    send_byte(8'h99, acc);
    wait_access("mid_thr_access", 1'b1, BASE);
    check("mid_thr_data", out_pwdata, 32'h0000_0099);
    #1 reset = 1'b0;
    #1;
    check("mid_psel",      out_psel,    1'b0);
    check("mid_penable",   out_penable, 1'b0);
    check("mid_tx_ready",  tx_ready,    1'b1);
    check("mid_init_done", init_done,   1'b0);
    check("mid_err_clr",   err,         1'b0);
    @(negedge clock);
    @(negedge clock);
    xlog.delete();
    reset = 1'b1;
    repeat (60) @(negedge clock);
    check("re_nlog", xlog.size() >= 4, 1'b1);
    if (xlog.size() >= 4) begin
      check("re_init0_addr",  xlog[0].addr,  BASE + 3);
      check("re_init0_wdata", xlog[0].wdata, 32'h8300_0000);
      check("re_init1_wdata", xlog[1].wdata, 32'h0000_0002);
      check("re_init3_wdata", xlog[3].wdata, 32'h0300_0000);
    end
    n = 0;
    foreach (xlog[i]) if (xlog[i].write && xlog[i].addr == BASE && xlog[i].wdata == 32'h0000_0099) n++;
    check("re_no_old_byte", n, 0);
    check("re_init_done",   init_done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
